// File: rtl/nqueens_pkg.sv
// Shared types and index helpers for the N-Queens backtracking solver.
// Holds the FSM state enum, the column-index width function and diagonal maps.
package nqueens_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRY,
        BACKTRACK,
        FOUND,
        DONE
    } state_e;

    // Width of one queen column index for an n x n board.
    function automatic int nq_col_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Left diagonal: cells with equal row+col share it.
    function automatic int unsigned ldiag_idx(input int unsigned row,
                                              input int unsigned col);
        return row + col;
    endfunction

    // Right diagonal: cells with equal row-col share it, offset to be >= 0.
    function automatic int unsigned rdiag_idx(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned n);
        return row + n - 1 - col;
    endfunction

endpackage

// File: rtl/nqueens_occupancy.sv
// Column and diagonal occupancy bookkeeping for the N-Queens solver.
// Ports: clk/reset (async active-low); clr_all wipes the board; set/clr
// place or remove the queen at upd_row/upd_col; safe reports whether
// chk_row/chk_col is unattacked by the queens currently on the board.
module nqueens_occupancy
    import nqueens_pkg::*;
#(
    parameter int N     = 8,
    parameter int COL_W = nq_col_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_all,
    input  logic             set,
    input  logic             clr,
    input  logic [COL_W-1:0] chk_row,
    input  logic [COL_W-1:0] chk_col,
    input  logic [COL_W-1:0] upd_row,
    input  logic [COL_W-1:0] upd_col,
    output logic             safe
);

    // 2N-1 diagonals always fit in COL_W+1 index bits; vectors are sized
    // to the full index range so every index is in bounds by construction.
    localparam int DW = COL_W + 1;
    localparam int CV = 1 << COL_W;
    localparam int DV = 1 << DW;

    logic [CV-1:0] col_used_q, col_used_d;
    logic [DV-1:0] ldiag_q, ldiag_d;
    logic [DV-1:0] rdiag_q, rdiag_d;

    logic [DW-1:0] chk_l, chk_r, upd_l, upd_r;

    assign chk_l = DW'(ldiag_idx(32'(chk_row), 32'(chk_col)));
    assign chk_r = DW'(rdiag_idx(32'(chk_row), 32'(chk_col), N));
    assign upd_l = DW'(ldiag_idx(32'(upd_row), 32'(upd_col)));
    assign upd_r = DW'(rdiag_idx(32'(upd_row), 32'(upd_col), N));

    assign safe = ~col_used_q[chk_col] & ~ldiag_q[chk_l] & ~rdiag_q[chk_r];

    always_comb begin
        col_used_d = col_used_q;
        ldiag_d    = ldiag_q;
        rdiag_d    = rdiag_q;
        if (clr_all) begin
            col_used_d = '0;
            ldiag_d    = '0;
            rdiag_d    = '0;
        end else if (set) begin
            col_used_d[upd_col] = 1'b1;
            ldiag_d[upd_l]      = 1'b1;
            rdiag_d[upd_r]      = 1'b1;
        end else if (clr) begin
            col_used_d[upd_col] = 1'b0;
            ldiag_d[upd_l]      = 1'b0;
            rdiag_d[upd_r]      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_used_q <= '0;
            ldiag_q    <= '0;
            rdiag_q    <= '0;
        end else begin
            col_used_q <= col_used_d;
            ldiag_q    <= ldiag_d;
            rdiag_q    <= rdiag_d;
        end
    end

endmodule

// File: rtl/nqueens_solver.sv
// Parametrised N-Queens backtracking engine: first-solution or enumerate-all.
// Ports: clk, reset (async active-low), start/mode/abort control, busy/done
// status, sol_valid/sol_ready/sol_cols solution stream, sol_count total.
// Optional NQUEENS_CYCLE_CNT_EN adds a 32-bit saturating busy-cycle counter
// on output port cycles.
module nqueens_solver
    import nqueens_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int COL_W = nq_col_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N*COL_W-1:0] sol_cols,
    output logic [CNT_W-1:0]   sol_count
`ifdef NQUEENS_CYCLE_CNT_EN
    ,
    output logic [31:0]        cycles
`endif
);

    localparam logic [COL_W-1:0] LAST = COL_W'(N - 1);
    localparam logic [COL_W-1:0] ONE  = COL_W'(1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [COL_W-1:0] q_q [N];
    logic [COL_W-1:0] q_d [N];

    logic             occ_set, occ_clr, occ_clr_all, safe;
    logic [COL_W-1:0] upd_row, upd_col;
    logic [COL_W-1:0] bt_row, bt_col, top_col;

    assign bt_row  = row_q - ONE;
    assign bt_col  = q_q[bt_row];
    assign top_col = q_q[N-1];

    nqueens_occupancy #(
        .N     (N),
        .COL_W (COL_W)
    ) u_occ (
        .clk     (clk),
        .reset   (reset),
        .clr_all (occ_clr_all),
        .set     (occ_set),
        .clr     (occ_clr),
        .chk_row (row_q),
        .chk_col (col_q),
        .upd_row (upd_row),
        .upd_col (upd_col),
        .safe    (safe)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        q_d         = q_q;
        occ_set     = 1'b0;
        occ_clr     = 1'b0;
        occ_clr_all = 1'b0;
        upd_row     = row_q;
        upd_col     = col_q;
        // Abort wins over everything, including a same-cycle transfer.
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        occ_clr_all = 1'b1;
                        row_d       = '0;
                        col_d       = '0;
                        cnt_d       = '0;
                        mode_d      = mode;
                        for (int i = 0; i < N; i++) q_d[i] = '0;
                        state_d     = TRY;
                    end
                end
                TRY: begin
                    if (safe) begin
                        occ_set    = 1'b1;
                        q_d[row_q] = col_q;
                        if (row_q == LAST) begin
                            state_d = FOUND;
                        end else begin
                            row_d = row_q + ONE;
                            col_d = '0;
                        end
                    end else if (col_q == LAST) begin
                        state_d = BACKTRACK;
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
                BACKTRACK: begin
                    if (row_q == '0) begin
                        state_d = DONE;
                    end else begin
                        // Lift the queen of the previous row and resume
                        // one column to its right, or keep unwinding.
                        occ_clr = 1'b1;
                        upd_row = bt_row;
                        upd_col = bt_col;
                        row_d   = bt_row;
                        if (bt_col != LAST) begin
                            col_d   = bt_col + ONE;
                            state_d = TRY;
                        end
                    end
                end
                FOUND: begin
                    if (sol_ready) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        if (!mode_q) begin
                            state_d = DONE;
                        end else begin
                            occ_clr = 1'b1;
                            upd_row = LAST;
                            upd_col = top_col;
                            if (top_col != LAST) begin
                                col_d   = top_col + ONE;
                                state_d = TRY;
                            end else begin
                                state_d = BACKTRACK;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            for (int i = 0; i < N; i++) q_q[i] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            for (int i = 0; i < N; i++) q_q[i] <= q_d[i];
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sol_valid = (state_q == FOUND);
    assign sol_count = cnt_q;

    always_comb begin
        sol_cols = '0;
        for (int r = 0; r < N; r++) sol_cols[r*COL_W +: COL_W] = q_q[r];
    end

`ifdef NQUEENS_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE) begin
            if (start && !abort) cyc_d = '0;
        end else if (cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_nqueens_solver.sv
// Testbench for nqueens_solver: four boards (N=4,5,6,8) run side by side
// against a permutation-based solution list kept per board.
module tb_nqueens_solver;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode  = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] ready = 4'hF;
    logic [3:0] hold  = 4'h0;
    bit         rnd_ready = 1'b0;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    function automatic int n_of(input int g);
        case (g)
            0: return 4;
            1: return 5;
            2: return 6;
            default: return 8;
        endcase
    endfunction

    function automatic int cw_of(input int g);
        return (g == 1) ? 3 : 16;
    endfunction

    function automatic int nsol_lit(input int n);
        case (n)
            4: return 2;
            5: return 10;
            6: return 4;
            default: return 92;
        endcase
    endfunction

    // Lexicographically first solution, row 0 in the lowest nibble.
    function automatic int first_lit(input int n);
        case (n)
            4: return 32'h2031;
            5: return 32'h31420;
            6: return 32'h420531;
            default: return 32'h31625740;
        endcase
    endfunction

    task automatic cmp(input int g, input string nm,
                       input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL inst%0d %s: got %0h, expected %0h",
                     g, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int NN  = n_of(g);
        localparam int CW  = cw_of(g);
        localparam int CLW = $clog2(NN);
        localparam longint CMAX = (64'd1 << CW) - 1;

        logic              busy, done, sol_valid;
        logic [NN*CLW-1:0] sol_cols;
        logic [CW-1:0]     sol_count;
`ifdef NQUEENS_CYCLE_CNT_EN
        logic [31:0]       cycles;
`endif

        nqueens_solver #(.N(NN), .CNT_W(CW)) dut (
            .clk       (clk),
            .reset     (rst_n),
            .start     (start),
            .mode      (mode),
            .abort     (abort),
            .busy      (busy),
            .done      (done),
            .sol_valid (sol_valid),
            .sol_ready (ready[g]),
            .sol_cols  (sol_cols),
            .sol_count (sol_count)
`ifdef NQUEENS_CYCLE_CNT_EN
            ,
            .cycles    (cycles)
`endif
        );

        logic [NN*CLW-1:0] sols[$];

        // Every permutation in lexicographic order, kept if no two queens
        // share a diagonal; DFS order on the board matches this order.
        initial begin
            int p[NN];
            int i, j, t, d, a, b;
            bit more, ok;
            logic [NN*CLW-1:0] v;
            for (int x = 0; x < NN; x++) p[x] = x;
            more = 1'b1;
            while (more) begin
                ok = 1'b1;
                for (int x = 0; x < NN; x++)
                    for (int y = x + 1; y < NN; y++) begin
                        d = p[x] - p[y];
                        if (d < 0) d = -d;
                        if (d == y - x) ok = 1'b0;
                    end
                if (ok) begin
                    v = '0;
                    for (int r = 0; r < NN; r++) v[r*CLW +: CLW] = CLW'(p[r]);
                    sols.push_back(v);
                end
                i = NN - 2;
                while (i >= 0 && p[i] > p[i+1]) i--;
                if (i < 0) begin
                    more = 1'b0;
                end else begin
                    j = NN - 1;
                    while (p[j] < p[i]) j--;
                    t = p[i]; p[i] = p[j]; p[j] = t;
                    a = i + 1; b = NN - 1;
                    while (a < b) begin
                        t = p[a]; p[a] = p[b]; p[b] = t;
                        a++; b--;
                    end
                end
            end
            cmp(g, "model_nsol", sols.size(), nsol_lit(NN));
            v = sols[0];
            for (int r = 0; r < NN; r++)
                cmp(g, "model_first", v[r*CLW +: CLW],
                    (first_lit(NN) >> (4 * r)) & 15);
        end

        int  k = 0, xfers = 0;
        bit  run = 0, mode_l = 0;
        bit  p_start = 0, p_abort = 0, p_done = 0, p_stall = 0;
        logic [NN*CLW-1:0] p_cols;

        always @(negedge clk) begin
            if (!rst_n) begin
                cmp(g, "rst_flags", {busy, done, sol_valid}, 0);
                cmp(g, "rst_cols", sol_cols, 0);
                cmp(g, "rst_cnt", sol_count, 0);
                run = 0; k = 0; xfers = 0;
                p_start = 0; p_abort = 0; p_done = 0; p_stall = 0;
            end else begin
                if (p_start) cmp(g, "busy_rise", busy, 1);
                if (p_abort) cmp(g, "abort_idle", {busy, done}, 0);
                if (p_done) cmp(g, "busy_fall", busy, 0);
                if (!run) cmp(g, "idle_quiet", {busy, done, sol_valid}, 0);
                if (p_stall) begin
                    cmp(g, "stall_valid", sol_valid, 1);
                    cmp(g, "stall_cols", sol_cols, p_cols);
                end
                if (sol_valid) begin
                    if (k < sols.size()) cmp(g, "sol_cols", sol_cols, sols[k]);
                    else cmp(g, "extra_sol", k, sols.size() - 1);
                end
                cmp(g, "sol_count", sol_count,
                    (xfers > CMAX) ? CMAX : longint'(xfers));
                if (done) begin
                    cmp(g, "done_in_run", run, 1);
                    cmp(g, "done_busy", busy, 1);
                    cmp(g, "done_total", xfers, mode_l ? sols.size() : 1);
                    run = 0;
                end
                p_start = 0; p_abort = 0; p_stall = 0;
                p_done  = done;
                if (run && abort) begin
                    run = 0;
                    p_abort = 1;
                end else if (run) begin
                    if (sol_valid && ready[g]) begin
                        k++;
                        xfers++;
                    end else if (sol_valid) begin
                        p_stall = 1;
                        p_cols  = sol_cols;
                    end
                end else if (!busy && start && !abort) begin
                    run = 1; mode_l = mode; k = 0; xfers = 0;
                    p_start = 1;
                end
            end
        end

        always @(negedge rst_n) begin
            #1;
            cmp(g, "async_flags", {busy, done, sol_valid}, 0);
            cmp(g, "async_cols", sol_cols, 0);
            cmp(g, "async_cnt", sol_count, 0);
`ifdef NQUEENS_CYCLE_CNT_EN
            cmp(g, "async_cycles", cycles, 0);
`endif
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++)
                ready[g] = hold[g] ? 1'b0 :
                           (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    task automatic do_start(input logic m);
        @(posedge clk);
        #1 start = 1'b1;
        mode = m;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic bit any_busy();
        return gi[0].busy | gi[1].busy | gi[2].busy | gi[3].busy;
    endfunction

    task automatic wait_idle(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (!any_busy()) seen = 1'b1;
        end
        if (!seen) cmp(-1, "timeout_idle", 0, 1);
    endtask

    task automatic wait_valid0(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (gi[0].sol_valid) seen = 1'b1;
        end
        if (!seen) cmp(0, "timeout_valid", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_start(1'b0);
        wait_idle(20000);
        cmp(0, "first_cnt", gi[0].sol_count, 1);
        cmp(3, "first_cnt", gi[3].sol_count, 1);

        hold[0] = 1'b1;
        rnd_ready = 1'b1;
        do_start(1'b1);
        repeat (5) @(posedge clk);
        do_start(1'b0);
        wait_valid0(500);
        repeat (20) @(posedge clk);
        #1 hold[0] = 1'b0;
        wait_idle(60000);
        cmp(0, "all_cnt", gi[0].sol_count, 2);
        cmp(1, "all_cnt_sat", gi[1].sol_count, 7);
        cmp(2, "all_cnt", gi[2].sol_count, 4);
        cmp(3, "all_cnt", gi[3].sol_count, 92);
        rnd_ready = 1'b0;

        do_start(1'b1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        cmp(-1, "abort_busy", any_busy(), 0);

        do_start(1'b0);
        wait_idle(20000);
        cmp(3, "restart_cnt", gi[3].sol_count, 1);

        hold[0] = 1'b1;
        do_start(1'b1);
        wait_valid0(500);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #2;
        cmp(0, "mid_rst_valid", gi[0].sol_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold[0] = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
